// File: rtl/alu_pkg.sv
// Shared constants for the ALU sequencer: ALUOp codes, request classes, FSM states.
// Latency: n/a (constants only).
// Backpressure: n/a.
package alu_pkg;

  // ALUOp codes understood by the logic_unit; 4'hF is reserved and never driven.
  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_ADD     = 4'h1;
  localparam logic [3:0] OP_SUB     = 4'h2;
  localparam logic [3:0] OP_AND     = 4'h3;
  localparam logic [3:0] OP_OR      = 4'h4;
  localparam logic [3:0] OP_XOR     = 4'h5;
  localparam logic [3:0] OP_SLT     = 4'h6;
  localparam logic [3:0] OP_SH_LOAD = 4'h7;
  localparam logic [3:0] OP_SLL     = 4'h8;
  localparam logic [3:0] OP_SRL     = 4'h9;
  localparam logic [3:0] OP_SRA     = 4'hA;
  localparam logic [3:0] OP_BEQ     = 4'hB;
  localparam logic [3:0] OP_BNE     = 4'hC;
  localparam logic [3:0] OP_BGT     = 4'hD;
  localparam logic [3:0] OP_BLE     = 4'hE;

  // Request classes; 5..7 are not supported.
  localparam logic [2:0] CLS_ARITH  = 3'd0;
  localparam logic [2:0] CLS_LOGIC  = 3'd1;
  localparam logic [2:0] CLS_SHIFT  = 3'd2;
  localparam logic [2:0] CLS_SLT    = 3'd3;
  localparam logic [2:0] CLS_BRANCH = 3'd4;

  // Sequencer FSM states.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_SH_LD = 3'd2;
  localparam logic [2:0] ST_SH_EX = 3'd3;
  localparam logic [2:0] ST_CMP   = 3'd4;
  localparam logic [2:0] ST_FIN   = 3'd5;

endpackage

// File: rtl/alu_op_encode.sv
// Maps a request class + funct to its ALUOp code and flags unsupported combinations.
// Latency: combinational.
// Backpressure: none.
// Ports: op_class/funct in; op_code (operation code, shift/branch code for those
//        classes) and illegal out.
module alu_op_encode
  import alu_pkg::*;
(
  input  logic [2:0] op_class,
  input  logic [1:0] funct,
  output logic [3:0] op_code,
  output logic       illegal
);

  always_comb begin
    op_code = OP_NOP;
    illegal = 1'b0;
    case (op_class)
      CLS_ARITH: begin
        case (funct)
          2'd0:    op_code = OP_ADD;
          2'd1:    op_code = OP_SUB;
          default: illegal = 1'b1;
        endcase
      end
      CLS_LOGIC: begin
        case (funct)
          2'd0:    op_code = OP_AND;
          2'd1:    op_code = OP_OR;
          2'd2:    op_code = OP_XOR;
          default: illegal = 1'b1;
        endcase
      end
      CLS_SHIFT: begin
        case (funct)
          2'd0:    op_code = OP_SLL;
          2'd1:    op_code = OP_SRL;
          2'd2:    op_code = OP_SRA;
          default: illegal = 1'b1;
        endcase
      end
      CLS_SLT: op_code = OP_SLT;
      CLS_BRANCH: begin
        case (funct)
          2'd0:    op_code = OP_BEQ;
          2'd1:    op_code = OP_BNE;
          2'd2:    op_code = OP_BGT;
          default: op_code = OP_BLE;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Drives the logic_unit ALUOp sequence for one decoded request and returns result/verdicts.
// Latency start->done: ALU/SLT 2, SHIFT 3, BRANCH 2..UC_WAIT+1, illegal 1.
// Backpressure: start is only sampled in IDLE; starts while busy or in FIN are dropped.
// Ports: clk/reset; request start/op_class/funct/ovf_en; logic_unit ALUOp out and
//        ALUOut/OVERFLOW/ZERO/Update_UC in; status busy/done; captured result,
//        zero_flag, branch_taken, ovf_exc, illegal_op (all valid with done).
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4,
  parameter int UC_WAIT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op_class,
  input  logic [1:0]        funct,
  input  logic              ovf_en,
  output logic [OP_W-1:0]   ALUOp,
  input  logic [DATA_W-1:0] ALUOut,
  input  logic              OVERFLOW,
  input  logic              ZERO,
  input  logic              Update_UC,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              zero_flag,
  output logic              branch_taken,
  output logic              ovf_exc,
  output logic              illegal_op
);

  localparam int CNT_W = (UC_WAIT > 1) ? $clog2(UC_WAIT) : 1;

  logic [2:0]       state_q;
  logic [2:0]       cls_q;
  logic [1:0]       funct_q;
  logic             ovf_en_q;
  logic [CNT_W-1:0] cnt_q;

  logic [2:0] enc_class;
  logic [1:0] enc_funct;
  logic [3:0] enc_op;
  logic       enc_illegal;
  logic [3:0] op_drv;

  // In IDLE the encoder looks at the live request so legality is known at accept
  // time; afterwards it decodes the latched request.
  assign enc_class = (state_q == ST_IDLE) ? op_class : cls_q;
  assign enc_funct = (state_q == ST_IDLE) ? funct    : funct_q;

  alu_op_encode u_enc (
    .op_class (enc_class),
    .funct    (enc_funct),
    .op_code  (enc_op),
    .illegal  (enc_illegal)
  );

  always_comb begin
    op_drv = OP_NOP;
    case (state_q)
      ST_ISSUE, ST_SH_EX, ST_CMP: op_drv = enc_op;
      ST_SH_LD:                   op_drv = OP_SH_LOAD;
      default:                    op_drv = OP_NOP;
    endcase
  end

  assign ALUOp = OP_W'(op_drv);
  assign done  = (state_q == ST_FIN);
  assign busy  = (state_q != ST_IDLE) && (state_q != ST_FIN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cls_q        <= CLS_ARITH;
      funct_q      <= 2'd0;
      ovf_en_q     <= 1'b0;
      cnt_q        <= '0;
      result       <= '0;
      zero_flag    <= 1'b0;
      branch_taken <= 1'b0;
      ovf_exc      <= 1'b0;
      illegal_op   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cls_q    <= op_class;
            funct_q  <= funct;
            ovf_en_q <= ovf_en;
            cnt_q    <= '0;
            if (enc_illegal) begin
              // Nothing is issued to the logic_unit; report straight away.
              illegal_op   <= 1'b1;
              branch_taken <= 1'b0;
              ovf_exc      <= 1'b0;
              state_q      <= ST_FIN;
            end else begin
              illegal_op <= 1'b0;
              case (op_class)
                CLS_SHIFT:  state_q <= ST_SH_LD;
                CLS_BRANCH: state_q <= ST_CMP;
                default:    state_q <= ST_ISSUE;
              endcase
            end
          end
        end
        ST_ISSUE: begin
          result       <= ALUOut;
          zero_flag    <= ZERO;
          ovf_exc      <= OVERFLOW & ovf_en_q & (cls_q == CLS_ARITH);
          branch_taken <= 1'b0;
          state_q      <= ST_FIN;
        end
        ST_SH_LD: state_q <= ST_SH_EX;
        ST_SH_EX: begin
          result       <= ALUOut;
          zero_flag    <= ZERO;
          ovf_exc      <= 1'b0;
          branch_taken <= 1'b0;
          state_q      <= ST_FIN;
        end
        ST_CMP: begin
          // Taken as soon as Update_UC is seen; not taken once the wait budget runs out.
          if (Update_UC || (cnt_q == CNT_W'(UC_WAIT - 1))) begin
            result       <= ALUOut;
            zero_flag    <= ZERO;
            ovf_exc      <= 1'b0;
            branch_taken <= Update_UC;
            state_q      <= ST_FIN;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_FIN:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
